// File: rtl/wb_burst_ram_ctrl.sv
// Wishbone B4 burst master giving the CFU word-wide read/write access to system RAM.
// Latency: bus goes active the cycle after request accept; a read word reaches rd_* one cycle after its ack.
// Backpressure: stb is withheld while the read FIFO is full or no write beat is offered; req_ready is low while busy.
module wb_burst_ram_ctrl #(
  parameter  int ADDR_W     = 30,
  parameter  int DATA_W     = 32,
  parameter  int MAX_BURST  = 8,
  parameter  int FIFO_DEPTH = 4,
  localparam int SEL_W      = DATA_W / 8,
  localparam int LEN_W      = $clog2(MAX_BURST)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [SEL_W-1:0]  req_sel,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic              done,
  output logic              done_err,
  output logic [ADDR_W-1:0] cfu_ram_adr,
  output logic [DATA_W-1:0] cfu_ram_dat_mosi,
  output logic [SEL_W-1:0]  cfu_ram_sel,
  output logic              cfu_ram_cyc,
  output logic              cfu_ram_stb,
  output logic              cfu_ram_we,
  output logic [2:0]        cfu_ram_cti,
  output logic [1:0]        cfu_ram_bte,
  input  logic [DATA_W-1:0] cfu_ram_dat_miso,
  input  logic              cfu_ram_ack,
  input  logic              cfu_ram_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  beats_q, beats_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              err_q, err_d;
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [PTR_W:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

  logic busy;
  logic stb;
  logic beat_ack;
  logic beat_err;
  logic push;
  logic pop;

  // Strobe and per-beat handshake outcome; a full FIFO (count MSB set) holds off read beats.
  always_comb begin
    busy = (state_q == ST_READ) || (state_q == ST_WRITE);
    stb  = 1'b0;
    if (state_q == ST_READ) begin
      stb = ~cnt_q[PTR_W];
    end else if (state_q == ST_WRITE) begin
      stb = wr_valid;
    end
    beat_err = stb & cfu_ram_err;
    beat_ack = stb & cfu_ram_ack & ~cfu_ram_err;
    push     = beat_ack & (state_q == ST_READ);
    pop      = rd_ready & (cnt_q != '0);
  end

  // Request sequencing: latch on accept, advance address/beat per ack, finish on last ack or error.
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    len_d   = len_q;
    beats_d = beats_q;
    sel_d   = sel_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          adr_d   = req_addr;
          len_d   = req_len;
          sel_d   = req_sel;
          beats_d = '0;
          err_d   = 1'b0;
          state_d = req_we ? ST_WRITE : ST_READ;
        end
      end
      ST_READ, ST_WRITE: begin
        if (beat_err) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (beat_ack) begin
          adr_d   = adr_q + ADDR_W'(1);
          beats_d = beats_q + LEN_W'(1);
          if (beats_q == len_q) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Read FIFO pointer and occupancy update; simultaneous push and pop leaves the count unchanged.
  always_comb begin
    wptr_d = push ? wptr_q + PTR_W'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + PTR_W'(1) : rptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Controller and FIFO bookkeeping state; reset abandons any burst in flight without a done.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      adr_q   <= '0;
      len_q   <= '0;
      beats_q <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      len_q   <= len_d;
      beats_q <= beats_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // FIFO storage captures the bus read data on every accepted read beat.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= cfu_ram_dat_miso;
    end
  end

  assign req_ready        = (state_q == ST_IDLE);
  assign wr_ready         = (state_q == ST_WRITE) & beat_ack;
  assign rd_valid         = (cnt_q != '0);
  assign rd_data          = rd_valid ? mem_q[rptr_q] : '0;
  assign done             = (state_q == ST_DONE);
  assign done_err         = done & err_q;
  assign cfu_ram_adr      = busy ? adr_q : '0;
  assign cfu_ram_dat_mosi = (state_q == ST_WRITE) ? wr_data : '0;
  assign cfu_ram_sel      = stb ? sel_q : '0;
  assign cfu_ram_cyc      = busy;
  assign cfu_ram_stb      = stb;
  assign cfu_ram_we       = (state_q == ST_WRITE);
  // Single access is classic; a burst is incrementing until its final beat.
  assign cfu_ram_cti      = !busy ? 3'b000 :
                            (len_q == '0) ? 3'b000 :
                            (beats_q == len_q) ? 3'b111 : 3'b010;
  assign cfu_ram_bte      = 2'b00;

endmodule

// File: tb/tb_wb_burst_ram_ctrl.sv
// Bench for wb_burst_ram_ctrl: directed scenarios then randomized requests against a transaction model.
// The model predicts each beat's address/cti/sel, the read word stream and the done/err outcome.
// Inputs change at the falling edge; outputs are sampled 1-2 time units later.
module tb_wb_burst_ram_ctrl;
  localparam int ADDR_W     = 30;
  localparam int DATA_W     = 32;
  localparam int MAX_BURST  = 8;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid, req_ready, req_we;
  logic [29:0] req_addr;
  logic [2:0]  req_len;
  logic [3:0]  req_sel;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_data;
  logic        done, done_err;
  logic [29:0] cfu_ram_adr;
  logic [31:0] cfu_ram_dat_mosi, cfu_ram_dat_miso;
  logic [3:0]  cfu_ram_sel;
  logic        cfu_ram_cyc, cfu_ram_stb, cfu_ram_we;
  logic [2:0]  cfu_ram_cti;
  logic [1:0]  cfu_ram_bte;
  logic        cfu_ram_ack, cfu_ram_err;

  wb_burst_ram_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len), .req_sel(req_sel),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .done(done), .done_err(done_err),
    .cfu_ram_adr(cfu_ram_adr), .cfu_ram_dat_mosi(cfu_ram_dat_mosi), .cfu_ram_sel(cfu_ram_sel),
    .cfu_ram_cyc(cfu_ram_cyc), .cfu_ram_stb(cfu_ram_stb), .cfu_ram_we(cfu_ram_we),
    .cfu_ram_cti(cfu_ram_cti), .cfu_ram_bte(cfu_ram_bte),
    .cfu_ram_dat_miso(cfu_ram_dat_miso), .cfu_ram_ack(cfu_ram_ack), .cfu_ram_err(cfu_ram_err)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] salt;
  logic [31:0] exp_rd[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RAM contents as seen by the slave model: a fixed scramble of the word address.
  function automatic logic [31:0] rdat(input logic [29:0] a);
    return ({2'b00, a} * 32'h9E37_79B1) ^ salt;
  endfunction

  // One request from offer to completion (or to a reset at cycle abort_at).
  task automatic run_req(input bit we, input logic [29:0] addr, input int len, input logic [3:0] sel,
                         input int err_beat, input int ack_prob, input int ack_wait,
                         input int wrv_prob, input int rd_prob, input int rd_hold, input int abort_at);
    int          n_exp, beat, wait_cnt;
    bit          fin;
    logic [31:0] wdata [MAX_BURST];
    logic [29:0] ea;
    n_exp    = (err_beat >= 0) ? err_beat : len + 1;
    beat     = 0;
    wait_cnt = 0;
    fin      = 1'b0;
    salt     = $urandom;
    foreach (wdata[i]) wdata[i] = $urandom;
    @(negedge clk);
    rd_ready = 1'b0; wr_valid = 1'b0; cfu_ram_ack = 1'b0; cfu_ram_err = 1'b0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_len = len[2:0]; req_sel = sel;
    #1 chk("req_ready_idle", req_ready, 1);
    for (int c = 0; c < 500 && !fin; c++) begin
      @(negedge clk);
      req_valid = 1'b0; req_addr = $urandom; req_sel = $urandom; req_we = ~we;
      cfu_ram_ack = 1'b0; cfu_ram_err = 1'b0;
      if (c == abort_at) begin
        rd_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("rst_cyc", cfu_ram_cyc, 0);
        chk("rst_stb", cfu_ram_stb, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_req_ready", req_ready, 1);
        exp_rd.delete();
        fin = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
      end else begin
        wr_valid = we && (beat < len + 1) && ($urandom_range(99) < wrv_prob);
        wr_data  = wr_valid ? wdata[beat] : $urandom;
        rd_ready = (c >= rd_hold) && ($urandom_range(99) < rd_prob);
        cfu_ram_dat_miso = $urandom;
        #1;
        chk("rd_valid", rd_valid, exp_rd.size() != 0);
        if (rd_valid && rd_ready) begin
          if (exp_rd.size() == 0) chk("rd_extra", 1, 0);
          else chk("rd_data", rd_data, exp_rd.pop_front());
        end
        if (done) begin
          chk("done_cyc", cfu_ram_cyc, 0);
          chk("done_err", done_err, err_beat >= 0);
          chk("beats", beat, n_exp);
          fin = 1'b1;
        end else begin
          chk("cyc", cfu_ram_cyc, 1);
          chk("we", cfu_ram_we, we);
          chk("bte", cfu_ram_bte, 0);
          if (we) chk("stb_w", cfu_ram_stb, wr_valid);
          else    chk("stb_r", cfu_ram_stb, (exp_rd.size() + ((rd_valid && rd_ready) ? 1 : 0)) < FIFO_DEPTH);
          if (!we && rd_hold > 0 && ack_prob == 100 && ack_wait == 0 && len >= FIFO_DEPTH && c == rd_hold - 1)
            chk("bp_beats", beat, FIFO_DEPTH);
          if (cfu_ram_stb) begin
            ea = addr + beat[29:0];
            chk("adr", cfu_ram_adr, ea);
            chk("cti", cfu_ram_cti, (len == 0) ? 0 : ((beat == len) ? 7 : 2));
            chk("sel", cfu_ram_sel, sel);
            if (we) chk("mosi", cfu_ram_dat_mosi, wdata[beat]);
            if (beat == err_beat) begin
              cfu_ram_err = 1'b1;
            end else if (wait_cnt >= ack_wait && $urandom_range(99) < ack_prob) begin
              cfu_ram_ack      = 1'b1;
              cfu_ram_dat_miso = rdat(ea);
              if (!we) exp_rd.push_back(rdat(ea));
            end else begin
              wait_cnt++;
            end
          end else begin
            chk("sel_idle", cfu_ram_sel, 0);
          end
          #1;
          if (we) chk("wr_ready", wr_ready, cfu_ram_ack);
          if (cfu_ram_ack) begin
            beat++;
            wait_cnt = 0;
          end
        end
      end
    end
    if (!fin) chk("timeout", 0, 1);
    if (abort_at < 0 && fin) begin
      @(negedge clk);
      cfu_ram_ack = 1'b0; cfu_ram_err = 1'b0; rd_ready = 1'b0; wr_valid = 1'b0;
      #1;
      chk("done_pulse", done, 0);
      chk("req_ready_after", req_ready, 1);
      chk("cyc_after", cfu_ram_cyc, 0);
    end
  endtask

  // Pop everything the model still expects, then confirm the FIFO reads empty.
  task automatic drain();
    for (int c = 0; c < 50 && exp_rd.size() > 0; c++) begin
      @(negedge clk);
      rd_ready = 1'b1;
      #1;
      chk("drain_valid", rd_valid, 1);
      if (rd_valid) chk("drain_data", rd_data, exp_rd.pop_front());
    end
    @(negedge clk);
    rd_ready = 1'b0;
    #1 chk("drain_empty", rd_valid, 0);
  endtask

  initial begin
    int len, err_beat;
    logic [29:0] addr;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_len = '0; req_sel = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    cfu_ram_dat_miso = '0; cfu_ram_ack = 1'b0; cfu_ram_err = 1'b0;
    #2;
    chk("reset_req_ready", req_ready, 1);
    chk("reset_cyc", cfu_ram_cyc, 0);
    chk("reset_stb", cfu_ram_stb, 0);
    chk("reset_we", cfu_ram_we, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_done", done, 0);
    chk("reset_done_err", done_err, 0);
    chk("reset_wr_ready", wr_ready, 0);
    chk("reset_adr", cfu_ram_adr, 0);
    chk("reset_sel", cfu_ram_sel, 0);
    chk("reset_cti", cfu_ram_cti, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // single read with two wait states
    run_req(0, 30'h100, 0, 4'hF, -1, 100, 2, 0, 100, 0, -1);
    drain();
    // back-to-back read burst
    run_req(0, 30'h100, 7, 4'hF, -1, 100, 0, 0, 100, 0, -1);
    drain();
    // FIFO backpressure: consumer stalls for 20 cycles
    run_req(0, 30'h100, 7, 4'hF, -1, 100, 0, 0, 100, 20, -1);
    drain();
    // write burst with gaps in wr_valid
    run_req(1, 30'h200, 3, 4'h5, -1, 100, 0, 50, 0, 0, -1);
    // error on the third beat of a read burst
    run_req(0, 30'h300, 7, 4'hF, 2, 100, 0, 0, 0, 0, -1);
    chk("err_words", exp_rd.size(), 2);
    drain();
    // address wrap at the top of the word space
    run_req(0, 30'h3FFF_FFFE, 3, 4'hF, -1, 100, 0, 0, 100, 0, -1);
    drain();
    // reset while a burst is in flight with words buffered
    run_req(0, 30'h3FFF_FFFE, 7, 4'hF, -1, 100, 0, 0, 0, 0, 3);

    repeat (60) begin
      len      = $urandom_range(MAX_BURST - 1);
      err_beat = ($urandom_range(7) == 0) ? int'($urandom_range(len)) : -1;
      addr     = ($urandom_range(3) == 0) ? 30'h3FFF_FFFF - 30'($urandom_range(8)) : 30'($urandom);
      run_req($urandom_range(1), addr, len, 4'($urandom), err_beat,
              $urandom_range(100, 30), $urandom_range(2), $urandom_range(100, 30),
              $urandom_range(100, 20), 0, -1);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
